// File: rtl/sniffer_pkg.sv
// Shared types and constants for the flagged-string loader.
package sniffer_pkg;

  localparam int MAX_STRLEN = 17;
  localparam int LAST_IDX   = MAX_STRLEN - 1;

  // Right-aligned string: the last character received sits at index LAST_IDX.
  typedef logic [0:MAX_STRLEN-1][7:0] flagged_str_t;
  typedef logic [4:0]                 strlen_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMMIT  = 2'd2,
    ST_DISCARD = 2'd3
  } loader_state_e;

endpackage

// File: rtl/flagged_string_loader_if.sv
// Byte-write handshake into the flagged-string loader.
interface flagged_string_loader_if;

  logic       wr_valid;
  logic       wr_start;
  logic       wr_last;
  logic [7:0] wr_byte;
  logic       wr_ready;

  modport master (
    output wr_valid,
    output wr_start,
    output wr_last,
    output wr_byte,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_start,
    input  wr_last,
    input  wr_byte,
    output wr_ready
  );

endinterface

// File: rtl/flagged_shift_reg.sv
// Shadow buffer for a string under construction. New bytes enter at the top
// index and older bytes move toward index 0, so the buffer is always
// right-aligned and untouched low indices stay zero.
module flagged_shift_reg
  import sniffer_pkg::*;
(
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clear_i,
  input  logic         load_first_i,
  input  logic         shift_i,
  input  logic [7:0]   byte_i,
  output flagged_str_t data_o,
  output strlen_t      count_o
);

  flagged_str_t data_q, data_d;
  strlen_t      count_q, count_d;

  // Next-state: clear wins over load-first, which wins over shift.
  always_comb begin
    data_d  = data_q;
    count_d = count_q;
    if (clear_i) begin
      data_d  = '0;
      count_d = '0;
    end else if (load_first_i) begin
      data_d           = '0;
      data_d[LAST_IDX] = byte_i;
      count_d          = 5'd1;
    end else if (shift_i) begin
      for (int k = 0; k < LAST_IDX; k++) begin
        data_d[k] = data_q[k+1];
      end
      data_d[LAST_IDX] = byte_i;
      count_d          = count_q + 5'd1;
    end
  end

  // Buffer and count registers, synchronously cleared by reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      data_q  <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign data_o  = data_q;
  assign count_o = count_q;

endmodule

// File: rtl/flagged_string_loader.sv
// Flagged-string loader: collects a byte stream into a shadow buffer and
// publishes it atomically to the active string in a one-cycle COMMIT state.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for a start byte; bytes without start are dropped
//   LOAD    | appending bytes to the shadow buffer
//   COMMIT  | wr_ready low; shadow copied to the active string this cycle
//   DISCARD | string overflowed; dropping bytes until last or a new start
module flagged_string_loader
  import sniffer_pkg::*;
#(
  parameter int MAX_STRLEN = sniffer_pkg::MAX_STRLEN
) (
  input  logic                     clk,
  input  logic                     n_rst,
  flagged_string_loader_if.slave   wr,
  output flagged_str_t             flagged_string,
  output strlen_t                  strlen,
  output logic                     string_valid,
  output logic                     cmp_clear,
  output logic                     overflow_err
);

  localparam strlen_t MAX_LEN = strlen_t'(MAX_STRLEN);

  loader_state_e state_q, state_d;
  logic          ready_q;
  flagged_str_t  active_q;
  strlen_t       strlen_q;
  logic          valid_q;
  logic          cmp_clear_q, cmp_clear_d;
  logic          overflow_q;

  logic          xfer;
  logic          sr_clear, sr_load, sr_shift;
  logic          ovf_set;
  flagged_str_t  shadow;
  strlen_t       shadow_cnt;

  assign xfer = wr.wr_valid && ready_q;

  flagged_shift_reg u_shadow (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear_i      (sr_clear),
    .load_first_i (sr_load),
    .shift_i      (sr_shift),
    .byte_i       (wr.wr_byte),
    .data_o       (shadow),
    .count_o      (shadow_cnt)
  );

  // FSM next-state and shadow-buffer control.
  always_comb begin
    state_d  = state_q;
    sr_clear = 1'b0;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    ovf_set  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (xfer && wr.wr_start) begin
          sr_load = 1'b1;
          state_d = wr.wr_last ? ST_COMMIT : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          if (wr.wr_start) begin
            sr_load = 1'b1;
            state_d = wr.wr_last ? ST_COMMIT : ST_LOAD;
          end else if (shadow_cnt == MAX_LEN) begin
            // The byte would push the string past its maximum length.
            ovf_set  = 1'b1;
            sr_clear = 1'b1;
            state_d  = wr.wr_last ? ST_IDLE : ST_DISCARD;
          end else begin
            sr_shift = 1'b1;
            if (wr.wr_last) begin
              state_d = ST_COMMIT;
            end
          end
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
      end
      ST_DISCARD: begin
        if (xfer) begin
          if (wr.wr_start) begin
            sr_load = 1'b1;
            state_d = wr.wr_last ? ST_COMMIT : ST_LOAD;
          end else if (wr.wr_last) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The comparator clear pulse coincides with the new active string.
  always_comb begin
    cmp_clear_d = (state_q == ST_COMMIT);
  end

  // State, ready and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_q    <= (state_d != ST_COMMIT);
      overflow_q <= overflow_q | ovf_set;
    end
  end

  // Active string registers; updated only when leaving COMMIT.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      active_q    <= '0;
      strlen_q    <= '0;
      valid_q     <= 1'b0;
      cmp_clear_q <= 1'b0;
    end else begin
      cmp_clear_q <= cmp_clear_d;
      if (state_q == ST_COMMIT) begin
        active_q <= shadow;
        strlen_q <= shadow_cnt;
        valid_q  <= 1'b1;
      end
    end
  end

  assign wr.wr_ready     = ready_q;
  assign flagged_string  = active_q;
  assign strlen          = strlen_q;
  assign string_valid    = valid_q;
  assign cmp_clear       = cmp_clear_q;
  assign overflow_err    = overflow_q;

endmodule

// File: tb/tb_flagged_string_loader.sv
// Scoreboard bench for flagged_string_loader: the driver feeds byte streams
// into a string-level reference model that queues expected commits; a
// monitor checks every cmp_clear pulse and that the active string holds
// steady between pulses.
module tb_flagged_string_loader;
  import sniffer_pkg::*;

  typedef struct {
    logic [0:16][7:0] s;
    logic [4:0]       len;
  } exp_t;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  flagged_str_t flagged_string;
  strlen_t      strlen;
  logic         string_valid, cmp_clear, overflow_err;

  flagged_string_loader_if wif ();

  flagged_string_loader dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .wr             (wif),
    .flagged_string (flagged_string),
    .strlen         (strlen),
    .string_valid   (string_valid),
    .cmp_clear      (cmp_clear),
    .overflow_err   (overflow_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  exp_t sb[$];

  // Reference model: a string is a list of bytes; mode 0 idle, 1 loading, 2 discarding.
  logic [7:0] cur[$];
  int         mode = 0;
  bit         ovf_m = 1'b0;

  function automatic void chk(input string nm, input logic [159:0] got, input logic [159:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endfunction

  function automatic void push_exp();
    exp_t e;
    int   n;
    n     = cur.size();
    e.s   = '0;
    e.len = 5'(n);
    for (int i = 0; i < n; i++) e.s[17 - n + i] = cur[i];
    sb.push_back(e);
  endfunction

  function automatic void model_accept(input logic [7:0] b, input bit s, input bit l);
    if (s) begin
      cur.delete();
      cur.push_back(b);
      mode = 1;
      if (l) begin
        push_exp();
        mode = 0;
      end
    end else if (mode == 1) begin
      if (cur.size() == 17) begin
        ovf_m = 1'b1;
        mode  = l ? 0 : 2;
      end else begin
        cur.push_back(b);
        if (l) begin
          push_exp();
          mode = 0;
        end
      end
    end else if (mode == 2) begin
      if (l) mode = 0;
    end
  endfunction

  task automatic idle(input int n);
    wif.wr_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Called just after a falling edge; returns just after the falling edge that follows the transfer.
  task automatic send(input logic [7:0] b, input bit s, input bit l, input int gap);
    bit done;
    if (gap > 0) idle(gap);
    wif.wr_valid = 1'b1;
    wif.wr_byte  = b;
    wif.wr_start = s;
    wif.wr_last  = l;
    done = 1'b0;
    for (int t = 0; t < 50 && !done; t++) begin
      if (wif.wr_ready) begin
        model_accept(b, s, l);
        done = 1'b1;
      end
      @(negedge clk);
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got wr_ready=0 for 50 cycles want wr_ready=1");
    end
  endtask

  task automatic do_reset();
    n_rst        = 1'b0;
    wif.wr_valid = 1'b0;
    cur.delete();
    mode  = 0;
    ovf_m = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    chk("rst_ready", 160'(wif.wr_ready), 160'(0));
    chk("rst_string", 160'(flagged_string), 160'(0));
    chk("rst_strlen", 160'(strlen), 160'(0));
    chk("rst_valid", 160'(string_valid), 160'(0));
    chk("rst_cmp_clear", 160'(cmp_clear), 160'(0));
    chk("rst_overflow", 160'(overflow_err), 160'(0));
    n_rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 160'(wif.wr_ready), 160'(1));
  endtask

  // Monitor: every cmp_clear pops one expected commit; otherwise the active string must hold.
  initial begin
    logic [0:16][7:0] held_s;
    logic [4:0]       held_len;
    logic             held_v;
    exp_t             e;
    held_s   = '0;
    held_len = '0;
    held_v   = 1'b0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        held_s   = '0;
        held_len = '0;
        held_v   = 1'b0;
      end else if (cmp_clear) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_commit: got len=%0d str=%h want no cmp_clear", strlen, flagged_string);
        end else begin
          e = sb.pop_front();
          chk("commit_string", 160'(flagged_string), 160'(e.s));
          chk("commit_strlen", 160'(strlen), 160'(e.len));
          chk("commit_valid", 160'(string_valid), 160'(1));
          held_s   = e.s;
          held_len = e.len;
          held_v   = 1'b1;
        end
      end else begin
        chk("hold_active", {8'(string_valid), 8'(strlen), 136'(flagged_string)},
            {8'(held_v), 8'(held_len), 136'(held_s)});
      end
    end
  end

  initial begin
    int len;
    bit s, l, drop_last;
    wif.wr_valid = 1'b0;
    wif.wr_start = 1'b0;
    wif.wr_last  = 1'b0;
    wif.wr_byte  = 8'h00;
    @(negedge clk);
    do_reset();

    // "cat"
    send(8'h63, 1, 0, 0);
    send(8'h61, 0, 0, 0);
    send(8'h74, 0, 1, 0);
    idle(4);
    chk("cat_tail", 160'({flagged_string[14], flagged_string[15], flagged_string[16]}), 160'(24'h636174));
    chk("cat_overflow", 160'(overflow_err), 160'(0));

    // Exactly the maximum length.
    for (int i = 0; i < 17; i++) send(8'(8'h41 + i), i == 0, i == 16, 0);
    idle(4);
    chk("max_first", 160'(flagged_string[0]), 160'(8'h41));
    chk("max_last", 160'(flagged_string[16]), 160'(8'h51));
    chk("max_overflow", 160'(overflow_err), 160'(0));

    // Commit "cat", then an 18-byte string, then "ab".
    send(8'h63, 1, 0, 0);
    send(8'h61, 0, 0, 0);
    send(8'h74, 0, 1, 0);
    idle(3);
    for (int i = 0; i < 18; i++) send(8'(8'h20 + i), i == 0, i == 17, 0);
    idle(4);
    chk("ovf_set", 160'(overflow_err), 160'(ovf_m));
    chk("ovf_keeps_cat", 160'(strlen), 160'(3));
    send(8'h61, 1, 0, 0);
    send(8'h62, 0, 1, 0);
    idle(4);
    chk("ovf_sticky", 160'(overflow_err), 160'(1));

    // Restart mid-load: "xy" abandoned, "do" committed.
    send(8'h78, 1, 0, 0);
    send(8'h79, 0, 0, 0);
    send(8'h64, 1, 0, 0);
    send(8'h6F, 0, 1, 0);
    idle(4);

    // Single-byte strings back to back with wr_valid held high across COMMIT.
    send(8'h5A, 1, 1, 0);
    send(8'h11, 1, 1, 0);
    send(8'h33, 0, 0, 0);
    send(8'h34, 0, 1, 0);
    idle(4);

    // Reset mid-load and mid-commit.
    send(8'h70, 1, 0, 0);
    send(8'h71, 0, 0, 0);
    do_reset();
    send(8'h55, 1, 1, 0);
    do_reset();

    // Randomized strings, restarts, unterminated strings and stray bytes.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) send(8'($urandom), 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2));
      len       = $urandom_range(1, 20);
      drop_last = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < len; i++) begin
        s = (i == 0) || ($urandom_range(0, 11) == 0);
        l = (i == len - 1) && !drop_last;
        send(8'($urandom), s, l, $urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : 0);
      end
    end
    idle(6);
    chk("final_overflow", 160'(overflow_err), 160'(ovf_m));
    chk("scoreboard_empty", 160'(sb.size()), 160'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
